// File: rtl/kuznechik_pkg.sv
// Shared types and helpers for the kuznechik round-robin scheduler:
// block width, FSM state encoding and the wrapped index increment.
package kuznechik_pkg;

  localparam int BLOCK_W         = 128;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_DELIVER = 3'd4,
    ST_ACK     = 3'd5
  } sched_state_t;

  // Index following idx in a ring of n requesters.
  function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/kuznechik_rr_arb.sv
// Round-robin arbiter: picks the first requesting index at or after the
// pointer; the pointer moves past the winner when advance is strobed.
module kuznechik_rr_arb
  import kuznechik_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = ID_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ID_W'(wrap_next(32'(grant_idx), NUM_REQ));
    end
  end

endmodule

// File: rtl/kuznechik_rr_sched.sv
// Shares one kuznechik_cipher core between NUM_REQ requesters, round-robin.
// Optional watchdog that resets a hung core: define KUZ_SCHED_TIMEOUT_EN.
module kuznechik_rr_sched
  import kuznechik_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*BLOCK_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       res_valid_o,
  output logic [BLOCK_W-1:0]         res_data_o,
  output logic [ID_W-1:0]            res_id_o,
  output logic                       res_err_o,
  input  logic                       res_ready_i,
  output logic                       core_resetn_o,
  output logic [BLOCK_W-1:0]         core_data_o,
  output logic                       core_req_o,
  output logic                       core_ack_o,
  input  logic [BLOCK_W-1:0]         core_data_i,
  input  logic                       core_valid_i,
  input  logic                       core_busy_i,
  output logic                       busy_o
);

  sched_state_t       state;
  logic [ID_W-1:0]    id_q;
  logic [BLOCK_W-1:0] blk_q;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [BLOCK_W-1:0] sel_blk;
  logic               grant_go;
  logic               to_busy;

  assign grant_go = (state == ST_IDLE) && (|req_valid_i) && !core_busy_i;

  kuznechik_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk_i),
    .rst       (rst_i),
    .req       (req_valid_i),
    .advance   (grant_go),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_blk = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) sel_blk = req_data_i[k*BLOCK_W +: BLOCK_W];
    end
  end

`ifdef KUZ_SCHED_TIMEOUT_EN
  localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] to_cnt;
  logic [1:0]       to_phase;

  // Non-zero phase means the core is being held in reset after a timeout.
  assign to_busy = (to_phase != 2'd0);
`else
  assign to_busy = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      id_q          <= '0;
      blk_q         <= '0;
      req_ready_o   <= '0;
      res_valid_o   <= 1'b0;
      res_data_o    <= '0;
      res_id_o      <= '0;
      res_err_o     <= 1'b0;
      core_resetn_o <= 1'b0;
      core_data_o   <= '0;
      core_req_o    <= 1'b0;
      core_ack_o    <= 1'b0;
      busy_o        <= 1'b0;
`ifdef KUZ_SCHED_TIMEOUT_EN
      to_cnt        <= '0;
      to_phase      <= 2'd0;
`endif
    end else begin
      core_resetn_o <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (grant_go) begin
            req_ready_o <= grant;
            id_q        <= grant_idx;
            blk_q       <= sel_blk;
            busy_o      <= 1'b1;
            state       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          req_ready_o <= '0;
          core_data_o <= blk_q;
          core_req_o  <= 1'b1;
          state       <= ST_ISSUE;
        end
        ST_ISSUE: begin
          core_req_o <= 1'b0;
          if (!to_busy && (core_busy_i || core_valid_i)) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!to_busy && core_valid_i) begin
            res_data_o  <= core_data_i;
            res_id_o    <= id_q;
            res_valid_o <= 1'b1;
            state       <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          // A timed-out core was already reset, so it gets no ack.
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            res_err_o   <= 1'b0;
            core_ack_o  <= !res_err_o;
            state       <= ST_ACK;
          end
        end
        ST_ACK: begin
          core_ack_o <= 1'b0;
          if (!core_valid_i) begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

`ifdef KUZ_SCHED_TIMEOUT_EN
      if (to_phase == 2'd1) begin
        core_resetn_o <= 1'b0;
        to_phase      <= 2'd2;
      end else if (to_phase == 2'd2) begin
        to_phase    <= 2'd0;
        res_valid_o <= 1'b1;
        res_err_o   <= 1'b1;
        res_data_o  <= '0;
        res_id_o    <= id_q;
        state       <= ST_DELIVER;
      end else if (state == ST_GRANT || (state == ST_ISSUE && (core_busy_i || core_valid_i))) begin
        to_cnt <= '0;
      end else if (state == ST_ISSUE || (state == ST_WAIT && !core_valid_i)) begin
        if (to_cnt == TO_LAST) begin
          core_resetn_o <= 1'b0;
          to_phase      <= 2'd1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule
